// File: rtl/life_row_stepper.sv
// Conway next-generation engine: streams the board one row per cycle through a
// prev/cur/nxt window and writes each new row back. Optional macro: TORUS_WRAP_EN.
module life_row_stepper #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int GEN_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [$clog2(HEIGHT)-1:0] rd_addr,
    input  logic [WIDTH-1:0]          rd_row,
    output logic [WIDTH-1:0]          wr_row,
    output logic [$clog2(HEIGHT)-1:0] wr_addr,
    output logic                      wr_en,
    output logic                      busy,
    output logic                      done,
    output logic [GEN_W-1:0]          gen_count
);
    localparam int AW = $clog2(HEIGHT);
    localparam logic [AW-1:0] LAST_ROW = AW'(HEIGHT - 1);

`ifdef TORUS_WRAP_EN
    typedef enum logic [2:0] {IDLE, PRIME_LAST, PRIME_FIRST, RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
`endif

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cur;
    logic [AW-1:0]    r_row;
    logic [WIDTH-1:0] r_wr_row;
    logic [AW-1:0]    r_wr_addr;
    logic             r_wr_en;
    logic             r_done;
    logic [GEN_W-1:0] r_gen_count;
    logic             w_last;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH+1:0] w_prev_x;
    logic [WIDTH+1:0] w_cur_x;
    logic [WIDTH+1:0] w_nxt_x;

    assign w_last = (r_row == LAST_ROW);

`ifdef TORUS_WRAP_EN
    // Row 0 is overwritten before the last row needs it as its lower neighbour.
    logic [WIDTH-1:0] r_row0_save;
    assign w_nxt    = w_last ? r_row0_save : rd_row;
    assign w_prev_x = {r_prev[0], r_prev, r_prev[WIDTH-1]};
    assign w_cur_x  = {r_cur[0],  r_cur,  r_cur[WIDTH-1]};
    assign w_nxt_x  = {w_nxt[0],  w_nxt,  w_nxt[WIDTH-1]};
`else
    assign w_nxt    = w_last ? '0 : rd_row;
    assign w_prev_x = {1'b0, r_prev, 1'b0};
    assign w_cur_x  = {1'b0, r_cur,  1'b0};
    assign w_nxt_x  = {1'b0, w_nxt,  1'b0};
`endif

    // Padded bit j holds column j-1, so column gi sees pads gi..gi+2.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            logic [3:0] w_n;
            assign w_n = 4'(w_prev_x[gi]) + 4'(w_prev_x[gi+1]) + 4'(w_prev_x[gi+2])
                       + 4'(w_cur_x[gi])                       + 4'(w_cur_x[gi+2])
                       + 4'(w_nxt_x[gi])  + 4'(w_nxt_x[gi+1])  + 4'(w_nxt_x[gi+2]);
            assign w_result[gi] = (w_n == 4'd3) || (r_cur[gi] && (w_n == 4'd2));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        rd_addr      = '0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
`ifdef TORUS_WRAP_EN
                if (start) w_state_next = PRIME_LAST;
            end
            PRIME_LAST: begin
                rd_addr      = LAST_ROW;
                w_state_next = PRIME_FIRST;
            end
            PRIME_FIRST: w_state_next = RUN;
`else
                if (start) w_state_next = PRIME;
            end
            PRIME: w_state_next = RUN;
`endif
            RUN: begin
                rd_addr = w_last ? '0 : r_row + 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev      <= '0;
            r_cur       <= '0;
            r_row       <= '0;
            r_wr_row    <= '0;
            r_wr_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_done      <= 1'b0;
            r_gen_count <= '0;
`ifdef TORUS_WRAP_EN
            r_row0_save <= '0;
`endif
        end else begin
            r_wr_en <= (r_state == RUN);
            r_done  <= (r_state == DONE);
            case (r_state)
`ifdef TORUS_WRAP_EN
                PRIME_LAST: r_prev <= rd_row;
                PRIME_FIRST: begin
                    r_cur       <= rd_row;
                    r_row0_save <= rd_row;
                    r_row       <= '0;
                end
`else
                PRIME: begin
                    r_cur  <= rd_row;
                    r_prev <= '0;
                    r_row  <= '0;
                end
`endif
                RUN: begin
                    r_wr_row  <= w_result;
                    r_wr_addr <= r_row;
                    r_prev    <= r_cur;
                    r_cur     <= w_nxt;
                    r_row     <= r_row + 1'b1;
                end
                DONE:    r_gen_count <= r_gen_count + 1'b1;
                default: ;
            endcase
        end
    end

    assign wr_row    = r_wr_row;
    assign wr_addr   = r_wr_addr;
    assign wr_en     = r_wr_en;
    assign done      = r_done;
    assign gen_count = r_gen_count;
endmodule

// File: doc/life_row_stepper.md
Name: life_row_stepper

Overview:
Next-generation engine for the Conway board. The board is a bank of HEIGHT row registers of WIDTH bits, each a `dff` with `d`, `we`, `clk`, `reset` and `q` ports. This block sits directly upstream of that bank. It reads the current board one row per cycle through a read address and row-data port, computes each row's next state with a three-row sliding window, and drives the row-write data, address and enable that feed the bank's `d`/`we`. One `start` pulse advances the board exactly one generation.

Parameters:
WIDTH, 8, cells per row. Bit i is column i. Must be at least 3.
HEIGHT, 8, number of rows. Must be at least 3.
GEN_W, 16, width of the generation counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to compute one generation; ignored while busy=1
rd_addr  output  $clog2(HEIGHT)  row index being read; combinational from state and row counter
rd_row  input  WIDTH  current contents of row rd_addr; combinational mux of bank q outputs, valid in the same cycle
wr_row  output  WIDTH  next-generation row data; drives the bank's d
wr_addr  output  $clog2(HEIGHT)  row index for wr_row; decoded externally into per-row we
wr_en  output  1  write strobe for wr_row/wr_addr
busy  output  1  high from the PRIME cycle through the DONE cycle inclusive
done  output  1  one-cycle pulse after the final row write
gen_count  output  GEN_W  completed-generation counter

Behaviour:
- FSM states: IDLE, PRIME, RUN, DONE.
- Reset (synchronous, overrides everything, including mid-run):
  - state=IDLE; wr_en=0, wr_row=0, wr_addr=0, done=0, gen_count=0.
  - Window registers prev/cur and row counter r cleared.
  - Any partially written generation is abandoned. Rows already written keep their new values.
- IDLE:
  - rd_addr=0, busy=0.
  - start=1 at an edge -> PRIME.
- PRIME:
  - rd_addr=0.
  - At the edge: cur<=rd_row; prev<=0; r<=0 -> RUN.
- RUN with row counter r:
  - rd_addr=r+1 if r<HEIGHT-1, else 0.
  - nxt = rd_row if r<HEIGHT-1, else all-zero.
  - Each cell's next state is computed from prev, cur and nxt:
    - Neighbour count n is 0..8 (4-bit) over the 8 surrounding cells.
    - Columns outside 0..WIDTH-1 count as dead.
    - Next state is alive iff n==3, or (cur bit alive and n==2).
  - At the edge: wr_row<=result; wr_addr<=r; wr_en<=1; prev<=cur; cur<=nxt; r<=r+1.
  - If r==HEIGHT-1 at that edge -> DONE.
- Hazard-free ordering:
  - Row r is written only after row r+1 has been read.
  - The original contents of row r are retained in prev.
  - Therefore writes never corrupt pending reads.
- DONE:
  - wr_en=1 for row HEIGHT-1 (registered from the last RUN cycle).
  - At the edge: wr_en<=0; done<=1; gen_count<=gen_count+1 (wraps modulo 2^GEN_W) -> IDLE.
- done is high for exactly the first IDLE cycle after DONE, then returns to 0.
- Latency (start sampled at edge E):
  - wr_en is high in the HEIGHT cycles following edges E+2 .. E+HEIGHT+1, rows 0..HEIGHT-1 in order.
  - done is high after edge E+HEIGHT+2.
- wr_en is 0 in all states except as stated above. wr_row and wr_addr hold their last values when wr_en=0.
- start while busy=1 is dropped, not queued. start in the same cycle that done=1 is accepted.

Optional Feature:
TORUS_WRAP_EN:
- Defined: the board is toroidal.
  - Column -1 maps to WIDTH-1 and column WIDTH maps to 0.
  - In PRIME, rd_addr=HEIGHT-1 for one extra cycle and prev<=rd_row (original last row). PRIME becomes 2 cycles: PRIME_LAST, then PRIME_FIRST.
  - The original row 0 is saved in a row0_save register during PRIME_FIRST. In RUN with r==HEIGHT-1, nxt=row0_save.
  - All latencies grow by 1 cycle.
- Undefined: every out-of-board neighbour is dead; timing is exactly as specified above.

Test Plan:
1. Blinker: 8x8 board, column 3 alive in rows 2,3,4, start. Required response:
   - wr_en high for 8 consecutive cycles, wr_addr 0..7.
   - Row 3 written 8'b00011100; all other rows 8'b0.
   - done 1 cycle after the last write; gen_count=1.
2. Still life: 2x2 block at rows 4-5, columns 5-6 (8'b01100000). Run 3 generations -> both rows rewritten 8'b01100000 each time; gen_count=3.
3. Start while busy: pulse start again 3 cycles after the first -> exactly 8 writes, single done pulse, gen_count increments by 1.
4. Reset mid-run: assert reset in the RUN cycle with r=4 -> next cycle state IDLE, wr_en=0, busy=0, gen_count=0; a following start completes a normal 8-row generation.
5. Corner cells (0,0),(0,7),(7,0),(7,7) alive, one generation:
   - Without TORUS_WRAP_EN: all rows written 0.
   - With TORUS_WRAP_EN: rows 0 and 7 written 8'b10000001 (stable block across the wrap), and first wr_en occurs one cycle later than in scenario 1.
6. Empty board: start -> 8 writes of 0, done pulse; back-to-back start on the done cycle accepted, gen_count=2.
